// File: rtl/data_ram_slave.sv
// data_ram_slave: responder for execute-stage data-memory requests.
// Word-organised storage, size-derived write strobes, RISC-V load
// extension, configurable read latency (LATENCY, 1..4) with a busy
// indication for pipeline stall.
// Optional feature macro: DATA_RAM_ERR_EN enables misaligned/illegal
// access detection and the ram_err_o pulse; without it no checking is
// done, misaligned accesses are forced aligned and illegal funct3 acts as W.
module data_ram_slave #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        ram_r_ena_i,
  input  logic [31:0] ram_r_addr_i,
  input  logic        ram_w_ena_i,
  input  logic [31:0] ram_w_addr_i,
  input  logic [31:0] ram_w_data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ram_r_data_o,
  output logic        ram_r_valid_o,
  output logic        ram_busy_o,
  output logic        ram_err_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // FSM encoding
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // Access size codes decoded from funct3
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Cycles left to count in WAIT after the accepting edge
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  // Illegal funct3 values fall through to word size.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  // Byte lane of the access; halves and words force low bits to zero.
  function automatic logic [1:0] lane_of(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_B:    lane_of = a;
      SZ_H:    lane_of = {a[1], 1'b0};
      default: lane_of = 2'b00;
    endcase
  endfunction

  logic [31:0]           mem_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [31:0]           pend_data_q, pend_data_d;
  logic                  pend_err_q, pend_err_d;

  logic                  rd_acc, wr_acc;
  logic                  r_fault, w_fault;
  logic [1:0]            sz;
  logic [1:0]            r_off, w_off;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx;
  logic [3:0]            w_strb;
  logic [31:0]           w_lanes;
  logic [31:0]           r_word, r_shift, r_ext, r_result;

  // Requests are only taken while no read is outstanding.
  assign rd_acc = ram_r_ena_i & (state_q == S_IDLE);
  assign wr_acc = ram_w_ena_i & (state_q == S_IDLE);

  assign sz    = size_of(funct3_i);
  assign r_off = lane_of(sz, ram_r_addr_i[1:0]);
  assign w_off = lane_of(sz, ram_w_addr_i[1:0]);
  assign r_idx = ram_r_addr_i[DEPTH_LOG2+1:2];
  assign w_idx = ram_w_addr_i[DEPTH_LOG2+1:2];

`ifdef DATA_RAM_ERR_EN
  logic illegal_f3;
  assign illegal_f3 = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
  assign r_fault = illegal_f3
                 || ((sz == SZ_H) && ram_r_addr_i[0])
                 || ((sz == SZ_W) && (ram_r_addr_i[1:0] != 2'b00));
  // Unsigned variants have no store meaning.
  assign w_fault = illegal_f3 || funct3_i[2]
                 || ((sz == SZ_H) && ram_w_addr_i[0])
                 || ((sz == SZ_W) && (ram_w_addr_i[1:0] != 2'b00));
  assign ram_err_o = err_q;
`else
  logic unused_err;
  assign r_fault    = 1'b0;
  assign w_fault    = 1'b0;
  assign unused_err = err_q;
  assign ram_err_o  = 1'b0;
`endif

  // Byte strobes and lane-replicated store data for an accepted, legal write
  always_comb begin
    w_strb  = 4'b0000;
    w_lanes = ram_w_data_i;
    case (sz)
      SZ_B: begin
        w_strb  = 4'b0001 << w_off;
        w_lanes = {4{ram_w_data_i[7:0]}};
      end
      SZ_H: begin
        w_strb  = w_off[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{ram_w_data_i[15:0]}};
      end
      default: w_strb = 4'b1111;
    endcase
    if (!wr_acc || w_fault) w_strb = 4'b0000;
  end

  // Storage write port, byte-lane granular
  // NOTE: storage has no reset branch so it maps onto plain RAM; its contents survive arst_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_strb[i]) mem_q[w_idx][8*i +: 8] <= w_lanes[8*i +: 8];
    end
  end

  // Load path: write-first merge, lane select and sign/zero extension
  always_comb begin
    r_word = mem_q[r_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_strb[i] && (w_idx == r_idx)) r_word[8*i +: 8] = w_lanes[8*i +: 8];
    end
    r_shift = r_word >> {r_off, 3'b000};
    case (sz)
      SZ_B:    r_ext = funct3_i[2] ? {24'h0, r_shift[7:0]}
                                   : {{24{r_shift[7]}}, r_shift[7:0]};
      SZ_H:    r_ext = funct3_i[2] ? {16'h0, r_shift[15:0]}
                                   : {{16{r_shift[15]}}, r_shift[15:0]};
      default: r_ext = r_word;
    endcase
    r_result = r_fault ? 32'h0 : r_ext;
  end

  // Next-state logic: immediate completion for LATENCY=1, otherwise count in WAIT
  // NOTE: every _d signal gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    err_d       = wr_acc & w_fault;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          if (LATENCY == 1) begin
            valid_d = 1'b1;
            data_d  = r_result;
            err_d   = err_d | r_fault;
          end else begin
            state_d     = S_WAIT;
            cnt_d       = CNT_INIT;
            pend_data_d = r_result;
            pend_err_d  = r_fault;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
          valid_d = 1'b1;
          data_d  = pend_data_q;
          err_d   = err_d | pend_err_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      valid_q     <= 1'b0;
      data_q      <= 32'h0;
      err_q       <= 1'b0;
      pend_data_q <= 32'h0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
    end
  end

  assign ram_r_data_o  = data_q;
  assign ram_r_valid_o = valid_q;
  assign ram_busy_o    = (state_q == S_WAIT);

  // Upper address bits are ignored: storage wraps around.
  logic unused_addr;
  assign unused_addr = ^{ram_r_addr_i[31:DEPTH_LOG2+2], ram_w_addr_i[31:DEPTH_LOG2+2]};

endmodule

// File: doc/data_ram_slave.md
Name: data_ram_slave

Overview:
- Responder end of the execute-stage data-memory request interface. It accepts read and write requests from the execute stage, serves them from internal word-organised storage and returns load data to the mem stage.
- Write strobes are derived from the access size. Load results are sign- or zero-extended per RISC-V funct3.
- Configurable read latency; a busy signal tells ctrl to stall the pipeline while a read is outstanding.

Parameters:
- DEPTH_LOG2, 12, number of 32-bit words = 2**DEPTH_LOG2; word index = addr[DEPTH_LOG2+1:2], upper address bits ignored (wrap-around).
- LATENCY, 1, read latency in cycles, legal 1..4.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- ram_r_ena_i  in  1  read request.
- ram_r_addr_i  in  32  read byte address.
- ram_w_ena_i  in  1  write request.
- ram_w_addr_i  in  32  write byte address.
- ram_w_data_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ram_r_data_o  out  32  extended load result.
- ram_r_valid_o  out  1  one-cycle pulse, ram_r_data_o valid.
- ram_busy_o  out  1  read outstanding; to ctrl for stall.
- ram_err_o  out  1  one-cycle pulse on misaligned or illegal access.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latency counter 0. Storage contents are not cleared. A reset mid-read aborts the read, and no valid pulse follows.
- FSM states:
  - IDLE: accepts a request at a rising edge when ram_busy_o=0.
  - WAIT: counting. Entered only when LATENCY>1.
- Read, accepted at edge E0:
  - ram_r_valid_o=1 for exactly one cycle, starting after edge E0+LATENCY-1. ram_r_data_o is held until the next valid pulse.
  - LATENCY=1: busy never asserts; back-to-back reads give a valid pulse every cycle.
  - LATENCY=L>1: ram_busy_o=1 for the L-1 cycles after E0, then 0 in the valid cycle. A new request is accepted in the valid cycle.
- Requests while busy=1 are ignored. The requester holds them stable, and they are accepted on the edge after busy falls.
- Write: single cycle, committed at the accepting edge; never raises busy.
  - SB: lane addr[1:0] written.
  - SH: lanes {addr[1],0} and {addr[1],1} written.
  - SW: all 4 lanes written.
  - BU and HU are illegal for writes.
- Read and write accepted at the same edge: write-first. If the word indexes match, the read returns the newly written bytes merged with the old ones.
- Load extension:
  - B: selected byte, sign-extended from bit 7.
  - H: selected half, sign-extended from bit 15.
  - BU/HU: zero-extended.
  - W: whole word.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal means funct3 in {011,110,111}.
- Misaligned or illegal access:
  - Storage is unchanged.
  - A read still completes with the normal latency, returning 0 with valid=1.
  - ram_err_o pulses in the same cycle as valid (reads) or the cycle after acceptance (writes).
- Simultaneous read and write where only one is faulty: the good one completes normally; ram_err_o pulses once.

Optional Feature:
- Macro DATA_RAM_ERR_EN.
- Defined: misaligned/illegal detection and ram_err_o as described above.
- Undefined:
  - No checking. ram_err_o tied 0.
  - Misaligned H/W accesses use the address with the low bits forced to zero (H: addr[0]=0; W: addr[1:0]=0).
  - Illegal funct3 is treated as W.

Test Plan:
- LATENCY=1: SW 0x12345678 to 0x10, then LW 0x10 next cycle → valid the cycle after acceptance, data 0x12345678, busy stays 0.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80. LBU 0x13 → 0x00000080. LW 0x10 → 0x80345678.
- LATENCY=3: LH 0x10 held asserted → busy=1 for 2 cycles, then valid with data 0x00005678 (after test 1). The held request is not re-accepted while busy.
- Same-edge SW 0xDEADBEEF to 0x20 and LW 0x20 → valid with 0xDEADBEEF.
- With DATA_RAM_ERR_EN defined:
  - SW to 0x21 → ram_err_o pulses once; a following LW 0x20 returns the prior contents.
  - LH at 0x23 → valid with 0, err pulses with it.
- Reset (arst_n=0 for 1 cycle) during WAIT with LATENCY=4 → busy and valid are 0 from the next cycle, no valid pulse follows, and memory contents are preserved (LW returns the old value).
